data_sram_resp: RTL and testbench

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp.sv | 88 ++++++++
 tb/tb_data_sram_resp.sv | 111 +++++++++++
 2 files changed

// File: rtl/data_sram_resp.sv
// data_sram_resp: single-outstanding SRAM responder for the CPU data-access interface.
// Define DMEM_ALIGN_CHK_EN to flag misaligned/reserved-size accesses with err and suppress their writes.
module data_sram_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic                  r_wr;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_wdata;
  logic [31:0]           r_mem [2**DEPTH_LOG2];
  logic                  w_err, w_we, w_unused;

  assign addr_ok = reset && (r_state == IDLE) && req;
  assign data_ok = (r_state == RESP);
  assign err     = data_ok && w_err;
  assign rdata   = (data_ok && !r_wr && !w_err) ? r_mem[r_idx] : '0;
  assign w_we    = data_ok && r_wr && !w_err;

`ifdef DMEM_ALIGN_CHK_EN
  logic [1:0] r_size, r_alo;
  always_ff @(posedge clk)
    if (addr_ok) begin
      r_size <= size;
      r_alo  <= addr[1:0];
    end
  assign w_err    = (r_size == 2'd1 && r_alo[0]) || (r_size == 2'd2 && r_alo != 2'd0) || (r_size == 2'd3);
  assign w_unused = ^addr[31:DEPTH_LOG2+2];
`else
  assign w_err    = 1'b0;
  assign w_unused = ^{addr[31:DEPTH_LOG2+2], addr[1:0], size};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (addr_ok) begin
        w_cnt_nxt   = 4'(WAIT_CYCLES);
        w_state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        w_cnt_nxt   = r_cnt - 4'd1;
        w_state_nxt = (r_cnt <= 4'd1) ? RESP : WAIT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end

  always_ff @(posedge clk)
    if (addr_ok) begin
      r_wr    <= wr;
      r_idx   <= addr[DEPTH_LOG2+1:2];
      r_wstrb <= wstrb;
      r_wdata <= wdata;
    end

  // Byte merge lands on the edge that ends RESP, so a read accepted next sees it.
  always_ff @(posedge clk)
    if (w_we)
      for (int i = 0; i < 4; i++)
        if (r_wstrb[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: directed self-checking bench for data_sram_resp (DEPTH_LOG2=10, WAIT_CYCLES=2).
module tb_data_sram_resp;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        addr_ok, data_ok, err;
  logic [31:0] rdata;
  int          n_vec = 0, n_err = 0;

  data_sram_resp dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction accepted in the current cycle; response expected 3 cycles later.
  task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [3:0] st, input logic [31:0] d, input logic [31:0] exp_r, input logic exp_e);
    req = 1'b1; wr = w; size = sz; addr = a; wstrb = st; wdata = d;
    @(negedge clk);
    check({tag, ".addr_ok"}, 32'(addr_ok), 32'd1);
    check({tag, ".acc_data_ok"}, 32'(data_ok), 32'd0);
    @(posedge clk); #1 req = 1'b0;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      check({tag, ".wait_data_ok"}, 32'(data_ok), 32'd0);
      check({tag, ".wait_rdata"}, rdata, 32'd0);
      check({tag, ".wait_addr_ok"}, 32'(addr_ok), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({tag, ".data_ok"}, 32'(data_ok), 32'd1);
    check({tag, ".rdata"}, rdata, exp_r);
    check({tag, ".err"}, 32'(err), 32'(exp_e));
    @(posedge clk); #1;
  endtask

  initial begin
    req = 1'b1;
    #12;
    check("rst.addr_ok", 32'(addr_ok), 32'd0);
    check("rst.data_ok", 32'(data_ok), 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.err", 32'(err), 32'd0);
    req = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    txn("wr10", 1, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 0);
    txn("rd10", 0, 2'd2, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 0);
    txn("wrb11", 1, 2'd0, 32'h11, 4'b0010, 32'h0000AA00, 32'h0, 0);
    txn("rd10b", 0, 2'd2, 32'h10, 4'h0, 32'h0, 32'hDEADAAEF, 0);
    txn("wr14", 1, 2'd2, 32'h14, 4'hF, 32'hCAFEF00D, 32'h0, 0);

    req = 1'b1; wr = 1'b0; size = 2'd2;
    for (int c = 0; c < 8; c++) begin
      addr = (c < 4) ? 32'h10 : 32'h14;
      @(negedge clk);
      check($sformatf("held.addr_ok.c%0d", c), 32'(addr_ok), 32'((c == 0) || (c == 4)));
      check($sformatf("held.data_ok.c%0d", c), 32'(data_ok), 32'((c == 3) || (c == 7)));
      if (c == 3) check("held.rdata0", rdata, 32'hDEADAAEF);
      if (c == 7) check("held.rdata1", rdata, 32'hCAFEF00D);
      @(posedge clk); #1;
    end
    req = 1'b0;

    txn("wr1004", 1, 2'd2, 32'h1004, 4'hF, 32'h12345678, 32'h0, 0);
    txn("rd0004", 0, 2'd2, 32'h0004, 4'h0, 32'h0, 32'h12345678, 0);

    txn("wr20", 1, 2'd2, 32'h20, 4'hF, 32'h55AA55AA, 32'h0, 0);
    req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    @(negedge clk);
    check("abort.addr_ok", 32'(addr_ok), 32'd1);
    @(posedge clk); #1 wr = 1'b0;
    @(negedge clk); #1 reset = 1'b0;
    check("abort.rst_addr_ok", 32'(addr_ok), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort.data_ok", 32'(data_ok), 32'd0);
      check("abort.addr_ok_gated", 32'(addr_ok), 32'd0);
    end
    @(posedge clk); #1 reset = 1'b1;
    txn("rd20", 0, 2'd2, 32'h20, 4'h0, 32'h0, 32'h55AA55AA, 0);

`ifdef DMEM_ALIGN_CHK_EN
    txn("mis12", 1, 2'd2, 32'h12, 4'hF, 32'h11223344, 32'h0, 1);
    txn("rd10c", 0, 2'd2, 32'h10, 4'h0, 32'h0, 32'hDEADAAEF, 0);
`else
    txn("mis12", 1, 2'd2, 32'h12, 4'hF, 32'h11223344, 32'h0, 0);
    txn("rd10c", 0, 2'd2, 32'h10, 4'h0, 32'h0, 32'h11223344, 0);
`endif

    @(negedge clk);
    check("idle.data_ok", 32'(data_ok), 32'd0);
    check("idle.rdata", rdata, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
